nnet_core_arbiter: RTL and testbench
====================================

# nnet_core_arbiter

Shares one HLS neural-net core (FIFO-style `data_V` / `res_V` ports, fronted by `nnet_vector_wrapper`-style streams) between two requesting AXI streams. It grants the core to one requester per vector and feeds it exactly `size_in` words. It then collects exactly `size_out` result words and routes them back to that requester with `tlast` on the final word. It sits in the user section of a `noc_block_*` between the stream sources and the HLS core instance.

## Interface
- `DWIDTH`, 32: data width of all streams.
- `SIZE_W`, 16: width of the vector-length inputs.
- `ce_clk` in 1: compute-engine clock; all logic is synchronous to it.
- `ce_rst_n` in 1: asynchronous, active-low reset.
- `size_in` in SIZE_W: words per input vector; sampled at grant.
- `size_out` in SIZE_W: words per result vector; sampled at grant.
- `s0_tdata`/`s1_tdata` in DWIDTH each: requester input data.
- `s0_tvalid`/`s1_tvalid` in 1 each: requester input valid.
- `s0_tlast`/`s1_tlast` in 1 each: requester input last; checked only, never used for counting.
- `s0_tready`/`s1_tready` out 1 each: requester input ready.
- `nn_in_tdata` out DWIDTH, `nn_in_tvalid` out 1, `nn_in_tready` in 1: to core input (`valid`→`empty_n`, `ready`→`read`).
- `nn_out_tdata` in DWIDTH, `nn_out_tvalid` in 1, `nn_out_tready` out 1: from core output (`write`→`valid`, `full_n`←`ready`).
- `m0_tdata`/`m1_tdata` out DWIDTH, `m0_tvalid`/`m1_tvalid` out 1, `m0_tlast`/`m1_tlast` out 1, `m0_tready`/`m1_tready` in 1: per-requester result streams.
- `busy` out 1: high outside IDLE.
- `owner` out 1: current/last granted port.
- `vec_done` out 1: one-cycle pulse on the final result beat.
- `err_align` out 1: one-cycle pulse on a misplaced input `tlast`.
- `vec_count` out 32: completed vectors; wraps at 2^32.

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE:
  - If `size_in == 0` or `size_out == 0`, no grant; remain IDLE. This is the disable mode.
  - Otherwise, if exactly one `sN_tvalid` is high, grant that port.
  - If both are high, grant the port ≠ `rr`. `rr` is the last-served port; its reset value is 1, so port 0 wins the first tie.
  - On grant: register `owner`, latch `size_in`/`size_out`, clear `in_cnt`/`out_cnt`, go to FEED.
- FEED, combinational pass-through from owner:
  - `nn_in_tvalid = s_owner_tvalid`, `nn_in_tdata = s_owner_tdata`, `s_owner_tready = nn_in_tready`.
  - Non-owner `tready` = 0.
  - Each accepted beat increments `in_cnt`. On the beat where `in_cnt == size_in_l-1`, go to DRAIN.
  - `err_align` pulses on an accepted beat where `s_owner_tlast` disagrees with `(in_cnt == size_in_l-1)`. Counting is unaffected.
- DRAIN, combinational pass-through to owner:
  - `m_owner_tvalid = nn_out_tvalid`, `m_owner_tdata = nn_out_tdata`, `nn_out_tready = m_owner_tready`.
  - `m_owner_tlast = (out_cnt == size_out_l-1)`.
  - Non-owner `m` valid = 0.
  - On the last accepted beat: pulse `vec_done`, increment `vec_count`, set `rr = owner`, go to IDLE.
- In IDLE and FEED, `nn_out_tready` = 0 and both `m*_tvalid` = 0. Core results are held in the core, never dropped.
- Counters are SIZE_W bits. `size_in`/`size_out` changes after grant have no effect until the next grant.

## Timing
- Reset (async assert, sync deassert in the instantiating block) forces:
  - state = IDLE, `rr` = 1, `owner` = 0, counters = 0, `vec_count` = 0.
  - All `tvalid`, `tready`, `tlast`, `busy`, `vec_done`, `err_align` = 0.
- Reset mid-vector discards the vector. The HLS core must be reset from the same reset (`ap_rst = ~ce_rst_n`).
- Grant latency is 1 cycle: a request seen in IDLE at cycle N → FEED at N+1. The first word can transfer at N+1.
- Zero added data latency in FEED/DRAIN; all data paths are combinational pass-through. Registered outputs are `busy`, `owner`, `vec_done`, `err_align`, `vec_count`.
- IDLE → next grant: minimum 1 IDLE cycle between vectors. Throughput is size_in + size_out + core latency + 1 cycles per vector.
- `size_*_l == 1`: the first beat is also the last; transition occurs on that beat.
- Simultaneous requests: resolved only in IDLE. A request arriving during FEED/DRAIN waits; valid is held per AXI rules.
- Backpressure: `m_owner_tready` low stalls the core output. `nn_in_tready` low stalls the requester. No timeout.

## Test plan
- Single vector: size_in=4, size_out=2, s0 sends 4 words with tlast on 4th → core sees 4 words; m0 gets 2 words, tlast on 2nd; `vec_done` pulse; `vec_count`=1; m1 idle.
- Tie after reset: s0 and s1 valid together → port 0 served first, then port 1, then port 0 again (alternation over 3 vectors); results routed to the matching m port.
- Backpressure: random `nn_in_tready`/`m0_tready` toggling, size_in=10, size_out=5 → all 10 in and 5 out delivered in order; no extra beats; `nn_out_tready` never high outside DRAIN.
- Alignment: s1 asserts tlast on word 2 of size_in=4 → `err_align` pulses once; vector still consumes 4 words; result normal.
- Disable/resize: `size_in`=0 with s0 valid → no grant for 20 cycles, `busy`=0. Set size 3/3 mid-stream after grant of a 4/2 vector → the current vector uses 4/2 and the next uses 3/3.
- Reset mid-DRAIN: drop `ce_rst_n` after 1 of 2 results → all outputs 0 in the same cycle; after release, state IDLE and `vec_count`=0.

Source files
------------

// File: rtl/nnet_core_arbiter_if.sv
// Stream channel (data/valid/ready/last) shared by requester, core and result ports.
interface nnet_core_arbiter_if #(parameter int DWIDTH = 32);
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/nnet_core_arbiter.sv
// Two-requester arbiter for a shared HLS neural-net core: one vector per grant,
// size_in words in, size_out words back to the granted port with tlast on the final word.
module nnet_core_arbiter #(
  parameter int DWIDTH = 32,
  parameter int SIZE_W = 16
) (
  input  logic                ce_clk,
  input  logic                ce_rst_n,
  input  logic [SIZE_W-1:0]   size_in,
  input  logic [SIZE_W-1:0]   size_out,
  nnet_core_arbiter_if.slave  s0,
  nnet_core_arbiter_if.slave  s1,
  nnet_core_arbiter_if.master nn_in,
  nnet_core_arbiter_if.slave  nn_out,
  nnet_core_arbiter_if.master m0,
  nnet_core_arbiter_if.master m1,
  output logic                busy,
  output logic                owner,
  output logic                vec_done,
  output logic                err_align,
  output logic [31:0]         vec_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic                   rr;
  logic [SIZE_W-1:0]      size_in_l, size_out_l, in_cnt, out_cnt;
  logic [1:0]             s_tvalid, s_tlast, s_tready;
  logic [1:0]             m_tvalid, m_tlast, m_tready;
  logic [1:0][DWIDTH-1:0] s_tdata;
  logic                   nn_in_tvalid, nn_out_tready;
  logic                   grant, gnt_port, in_fire, out_fire, in_last, out_last;
  logic                   unused_tlast;

  assign s_tvalid = {s1.tvalid, s0.tvalid};
  assign s_tlast  = {s1.tlast,  s0.tlast};
  assign s_tdata  = {s1.tdata,  s0.tdata};
  assign m_tready = {m1.tready, m0.tready};

  assign s0.tready = s_tready[0];
  assign s1.tready = s_tready[1];
  assign m0.tvalid = m_tvalid[0];
  assign m1.tvalid = m_tvalid[1];
  assign m0.tlast  = m_tlast[0];
  assign m1.tlast  = m_tlast[1];
  assign m0.tdata  = nn_out.tdata;
  assign m1.tdata  = nn_out.tdata;

  assign nn_in.tvalid  = nn_in_tvalid;
  assign nn_in.tdata   = s_tdata[owner];
  assign nn_in.tlast   = 1'b0;
  assign nn_out.tready = nn_out_tready;
  assign unused_tlast  = nn_out.tlast;

  assign in_last  = (in_cnt  == size_in_l  - SIZE_W'(1));
  assign out_last = (out_cnt == size_out_l - SIZE_W'(1));

  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    gnt_port      = 1'b0;
    nn_in_tvalid  = 1'b0;
    nn_out_tready = 1'b0;
    s_tready      = '0;
    m_tvalid      = '0;
    m_tlast       = '0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        // zero sizes act as a disable: requests are left pending
        if (size_in != '0 && size_out != '0 && |s_tvalid) begin
          grant    = 1'b1;
          gnt_port = (&s_tvalid) ? ~rr : s_tvalid[1];
          state_d  = FEED;
        end
      end
      FEED: begin
        nn_in_tvalid    = s_tvalid[owner];
        s_tready[owner] = nn_in.tready;
        in_fire         = s_tvalid[owner] & nn_in.tready;
        if (in_fire && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        m_tvalid[owner] = nn_out.tvalid;
        m_tlast[owner]  = out_last;
        nn_out_tready   = m_tready[owner];
        out_fire        = nn_out.tvalid & m_tready[owner];
        if (out_fire && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q    <= IDLE;
      rr         <= 1'b1;
      owner      <= 1'b0;
      size_in_l  <= '0;
      size_out_l <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      vec_count  <= '0;
      busy       <= 1'b0;
      vec_done   <= 1'b0;
      err_align  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      vec_done  <= out_fire & out_last;
      // tlast is advisory only; a mismatch is flagged but never alters counting
      err_align <= in_fire & (s_tlast[owner] != in_last);
      if (grant) begin
        owner      <= gnt_port;
        size_in_l  <= size_in;
        size_out_l <= size_out;
        in_cnt     <= '0;
        out_cnt    <= '0;
      end
      if (in_fire) in_cnt <= in_cnt + SIZE_W'(1);
      if (out_fire) begin
        out_cnt <= out_cnt + SIZE_W'(1);
        if (out_last) begin
          vec_count <= vec_count + 32'd1;
          rr        <= owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_nnet_core_arbiter.sv
// Self-checking bench: plays both requesters and the HLS core, predicting grants,
// data ordering, tlast placement and status pulses from a per-vector queue model.
module tb_nnet_core_arbiter;
  localparam int DWIDTH = 32;
  localparam int SIZE_W = 16;

  logic ce_clk = 1'b0;
  logic ce_rst_n = 1'b0;
  logic [SIZE_W-1:0] size_in, size_out;
  logic busy, owner, vec_done, err_align;
  logic [31:0] vec_count;

  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) s0_if();
  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) s1_if();
  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) nn_in_if();
  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) nn_out_if();
  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) m0_if();
  nnet_core_arbiter_if #(.DWIDTH(DWIDTH)) m1_if();

  logic [1:0]             s_vld, s_lst, m_rdy;
  logic [1:0][DWIDTH-1:0] s_dat;
  logic                   nn_rdy, core_vld;
  logic [DWIDTH-1:0]      core_dat;
  logic [1:0]             s_rdy, m_vld, m_lst;
  logic [1:0][DWIDTH-1:0] m_dat;

  assign s0_if.tvalid = s_vld[0];
  assign s1_if.tvalid = s_vld[1];
  assign s0_if.tlast  = s_lst[0];
  assign s1_if.tlast  = s_lst[1];
  assign s0_if.tdata  = s_dat[0];
  assign s1_if.tdata  = s_dat[1];
  assign m0_if.tready = m_rdy[0];
  assign m1_if.tready = m_rdy[1];
  assign nn_in_if.tready = nn_rdy;
  assign nn_out_if.tvalid = core_vld;
  assign nn_out_if.tdata  = core_dat;
  assign nn_out_if.tlast  = 1'b0;
  assign s_rdy = {s1_if.tready, s0_if.tready};
  assign m_vld = {m1_if.tvalid, m0_if.tvalid};
  assign m_lst = {m1_if.tlast, m0_if.tlast};
  assign m_dat = {m1_if.tdata, m0_if.tdata};

  nnet_core_arbiter #(.DWIDTH(DWIDTH), .SIZE_W(SIZE_W)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .size_in(size_in), .size_out(size_out),
    .s0(s0_if), .s1(s1_if), .nn_in(nn_in_if), .nn_out(nn_out_if),
    .m0(m0_if), .m1(m1_if),
    .busy(busy), .owner(owner), .vec_done(vec_done), .err_align(err_align),
    .vec_count(vec_count)
  );

  always #5 ce_clk = ~ce_clk;

  int errors = 0;
  int checks = 0;
  bit rr_m = 1'b1;
  int vc_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_drive();
    s_vld = '0; s_lst = '0; s_dat = '0;
    nn_rdy = 1'b0; core_vld = 1'b0; core_dat = '0; m_rdy = '0;
  endtask

  // One vector: req = requesting ports, tl_mask = tlast per word index,
  // new_si/new_so > 0 resize after grant, rst_at >= 0 resets after that many results.
  task automatic run_vec(input bit [1:0] req, input int nin, input int nout, input bit bp,
                         input int tl_mask, input int new_si, input int new_so, input int rst_at);
    bit w;
    bit resized;
    int in_got, out_got, err_cnt, done_cnt, exp_err, cyc;
    logic [DWIDTH-1:0] words[$];
    logic [DWIDTH-1:0] res[$];
    w = (req == 2'b11) ? !rr_m : req[1];
    for (int i = 0; i < nin; i++) words.push_back($urandom);
    for (int i = 0; i < nout; i++) res.push_back($urandom);
    exp_err = 0;
    for (int i = 0; i < nin; i++) if (tl_mask[i] != (i == nin - 1)) exp_err++;
    in_got = 0; out_got = 0; err_cnt = 0; done_cnt = 0; cyc = 0; resized = 1'b0;
    size_in = SIZE_W'(nin); size_out = SIZE_W'(nout);
    while (out_got < nout) begin
      @(posedge ce_clk); #1;
      if (rst_at >= 0 && out_got == rst_at) begin
        ce_rst_n = 1'b0; #1;
        chk("rst_m_vld", m_vld, 0);
        chk("rst_m_lst", m_lst, 0);
        chk("rst_s_rdy", s_rdy, 0);
        chk("rst_nn_in_vld", nn_in_if.tvalid, 0);
        chk("rst_nn_out_rdy", nn_out_if.tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_vec_count", vec_count, 0);
        chk("rst_pulses", {vec_done, err_align}, 0);
        vc_m = 0; rr_m = 1'b1;
        idle_drive();
        @(negedge ce_clk); ce_rst_n = 1'b1;
        @(negedge ce_clk);
        chk("post_rst_busy", busy, 0);
        return;
      end
      if (new_si > 0 && busy && !resized) begin
        size_in = SIZE_W'(new_si); size_out = SIZE_W'(new_so); resized = 1'b1;
      end
      s_vld = '0; s_lst = '0;
      for (int p = 0; p < 2; p++)
        if (req[p] && p != int'(w)) begin s_vld[p] = 1'b1; s_dat[p] = 32'hA5A5_0000 | p; end
      s_vld[w] = (in_got < nin);
      s_dat[w] = (in_got < nin) ? words[in_got] : '0;
      s_lst[w] = tl_mask[in_got];
      nn_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      core_vld = (in_got == nin) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      core_dat = (out_got < nout) ? res[out_got] : '0;
      m_rdy = 2'($urandom);
      m_rdy[w] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge ce_clk);
      chk("nonowner_s_rdy", s_rdy[!w], 0);
      chk("nonowner_m_vld", m_vld[!w], 0);
      chk("nn_out_rdy_early", nn_out_if.tready & (in_got < nin), 0);
      if (nn_in_if.tvalid && nn_rdy) begin
        chk("in_extra", in_got < nin, 1);
        if (in_got < nin) chk("in_data", nn_in_if.tdata, words[in_got]);
        chk("s_rdy_pass", s_rdy[w], 1);
        in_got++;
      end
      if (m_vld[w] && m_rdy[w]) begin
        chk("out_extra", out_got < nout, 1);
        if (out_got < nout) begin
          chk("out_data", m_dat[w], res[out_got]);
          chk("out_last", m_lst[w], out_got == nout - 1);
        end
        chk("core_rdy", nn_out_if.tready, 1);
        out_got++;
      end
      err_cnt += int'(err_align);
      done_cnt += int'(vec_done);
      if (++cyc > 3000) begin
        chk("timeout", out_got, nout);
        break;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge ce_clk); #1;
      idle_drive();
      @(negedge ce_clk);
      err_cnt += int'(err_align);
      done_cnt += int'(vec_done);
    end
    vc_m++; rr_m = w;
    chk("in_count", in_got, nin);
    chk("vec_done_pulses", done_cnt, 1);
    chk("err_align_pulses", err_cnt, exp_err);
    chk("vec_count", vec_count, vc_m);
    chk("owner", owner, w);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_drive();
    size_in = 16'd4; size_out = 16'd2;
    repeat (3) @(posedge ce_clk);
    @(negedge ce_clk); ce_rst_n = 1'b1;
    @(negedge ce_clk);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_vec_count", vec_count, 0);
    chk("reset_pulses", {vec_done, err_align}, 0);
    chk("reset_nn_in_vld", nn_in_if.tvalid, 0);
    chk("reset_nn_out_rdy", nn_out_if.tready, 0);
    chk("reset_m_vld", m_vld, 0);

    // tie straight out of reset: port 0, then 1, then 0
    run_vec(2'b11, 3, 2, 1'b0, 1 << 2, 0, 0, -1);
    run_vec(2'b11, 3, 2, 1'b0, 1 << 2, 0, 0, -1);
    run_vec(2'b11, 3, 2, 1'b0, 1 << 2, 0, 0, -1);
    // single vector from s0
    run_vec(2'b01, 4, 2, 1'b0, 1 << 3, 0, 0, -1);
    // backpressure
    run_vec(2'b01, 10, 5, 1'b1, 1 << 9, 0, 0, -1);
    // misplaced tlast on word 2 (plus correct final tlast) from s1
    run_vec(2'b10, 4, 2, 1'b0, (1 << 1) | (1 << 3), 0, 0, -1);
    // minimum sizes
    run_vec(2'b10, 1, 1, 1'b1, 1, 0, 0, -1);

    // disable mode
    size_in = '0; size_out = 16'd2;
    s_vld[0] = 1'b1; s_dat[0] = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      @(negedge ce_clk);
      chk("disable_busy", busy, 0);
      chk("disable_s0_rdy", s_rdy[0], 0);
    end
    chk("disable_vec_count", vec_count, vc_m);
    @(posedge ce_clk); #1; idle_drive();

    // resize after grant: 4/2 now, 3/3 next
    run_vec(2'b01, 4, 2, 1'b0, 1 << 3, 3, 3, -1);
    chk("resize_held_in", size_in, 3);
    run_vec(2'b10, 3, 3, 1'b0, 1 << 2, 0, 0, -1);

    // randomized vectors
    for (int v = 0; v < 12; v++) begin
      int ni, no, msk;
      bit [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      ni = $urandom_range(1, 8);
      no = $urandom_range(1, 6);
      msk = ($urandom_range(0, 2) == 0) ? int'($urandom & ((1 << ni) - 1)) : (1 << (ni - 1));
      run_vec(rq, ni, no, 1'($urandom_range(0, 1)), msk, 0, 0, -1);
    end

    // reset in the middle of DRAIN, then tie must go to port 0 again
    run_vec(2'b01, 2, 2, 1'b0, 1 << 1, 0, 0, 1);
    run_vec(2'b11, 2, 1, 1'b0, 1 << 1, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
